adder_checker: RTL and testbench
================================

# adder_checker

Synthesizable response checker for the single-bit full-adder test harness. It consumes the same {A, B, Ci} vectors the stimulus side drives into an adder under test, together with that adder's S/Co outputs. For each vector it waits a programmable settle time to absorb gate delay, then compares S/Co against a golden sum. It accumulates pass/fail results so an on-chip or FPGA self-test can report the adder's correctness without a simulator.

## Interface
- SETTLE_CYCLES, 10: clock cycles from vector acceptance to S/Co sampling; legal range 1..255.
- VECTOR_COUNT, 8: vectors to check per run; legal range 1..255.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- vec_valid  in  1  one-cycle strobe: A/B/Ci hold a new vector.
- A  in  1  adder operand as driven to the DUT.
- B  in  1  adder operand as driven to the DUT.
- Ci  in  1  carry-in as driven to the DUT.
- S  in  1  DUT sum output.
- Co  in  1  DUT carry output.
- ready  out  1  high in ARMED; checker accepts vec_valid.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff err_count == 0 and no overrun.
- err_count  out  8  mismatches this run; saturates at 255.
- overrun  out  1  sticky; vec_valid arrived in SETTLE.
- first_fail  out  3  {A,B,Ci} of first mismatch.
- first_fail_vld  out  1  first_fail holds a captured vector.
- cov_mask  out  8  bit i set when vector i = {A,B,Ci} was checked (macro-dependent).

## Operation
- States: IDLE, ARMED, SETTLE, DONE.
- IDLE → ARMED on start.
  - Clears err_count, overrun, first_fail, first_fail_vld, vec_cnt and cov_mask.
- DONE → ARMED on start, with the same clears. DONE holds indefinitely otherwise.
- ARMED: vec_valid latches {A,B,Ci}, computes the golden {Co,S} = A+B+Ci (2-bit), loads the settle counter with SETTLE_CYCLES, and moves to SETTLE.
- SETTLE: the counter decrements each cycle. When it expires, live S/Co are compared to golden.
  - On mismatch, err_count increments (saturating).
  - On the first mismatch, the latched vector goes to first_fail and first_fail_vld is set.
  - vec_cnt increments. The next state is DONE if vec_cnt reaches VECTOR_COUNT, else ARMED.
- vec_valid in SETTLE: sets overrun, the vector is dropped, and the current check continues.
- vec_valid in IDLE or DONE: ignored.
- start in ARMED or SETTLE: ignored.
- Simultaneous start and vec_valid in DONE: start wins and the vector is ignored.

## Timing
- Reset values: state IDLE, ready 0, done 0, pass 0, err_count 0, overrun 0, first_fail 0, first_fail_vld 0, cov_mask 0.
- Reset mid-run aborts immediately to the reset values at the next edge.
- vec_valid accepted at edge E0.
- S/Co are sampled at edge E0+SETTLE_CYCLES.
- err_count, first_fail and vec_cnt updates are visible after that same edge.
- ready reasserts after that edge, or done asserts if it was the final vector.
- Minimum spacing between accepted vectors is SETTLE_CYCLES+1 cycles.
- pass is registered and valid in the same cycle done first asserts.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- ADDER_CHECKER_COVERAGE_EN defined:
  - cov_mask[{A,B,Ci}] is set at each check.
  - pass additionally requires cov_mask == 8'hFF when VECTOR_COUNT ≥ 8.
- Undefined: cov_mask is tied to 0 and pass ignores coverage.

## Structure
- Package adder_check_pkg holds:
  - state encoding constants IDLE=2'd0, ARMED=2'd1, SETTLE=2'd2, DONE=2'd3;
  - ERR_W = 8;
  - VEC_W = 3.
- Sub-module adder_golden: a combinational golden model, {A,B,Ci} → {Co,S}, written behaviourally as an addition. It is instantiated once and fed from the latched vector.

## Test plan
- Exhaustive correct DUT:
  - Stimulus: start, then vectors 0..7 spaced 12 cycles apart, SETTLE_CYCLES=10, S/Co driven correctly by edge E0+5.
  - Required: done after the 8th check, pass=1, err_count=0, first_fail_vld=0, cov_mask=8'hFF with the macro defined.
- Stuck-at fault:
  - Stimulus: Co forced to 0 across all 8 vectors.
  - Required: err_count=4, first_fail=3'b011, pass=0.
- Late response:
  - Stimulus: DUT outputs settle at E0+11 with SETTLE_CYCLES=10, driving the old value until then.
  - Required: a mismatch is counted for every vector whose golden result differs from the previous one.
- Overrun:
  - Stimulus: a second vec_valid 3 cycles after the first.
  - Required: overrun=1, the first check completes normally, vec_cnt counts 1 (not 2), final pass=0.
- Reset mid-SETTLE:
  - Stimulus: rst asserted at E0+4.
  - Required: state returns to IDLE, all outputs at reset values next cycle, and a later start/run behaves normally.
- Saturation and restart:
  - Stimulus: VECTOR_COUNT=255, all vectors mismatching, then start in DONE.
  - Required: err_count holds at 255 with no wrap; the restart clears it to 0 and re-enters ARMED.

Source files
------------

// File: rtl/adder_check_pkg.sv
// Shared types and widths for the full-adder response checker.
package adder_check_pkg;

  localparam int ERR_W = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/adder_golden.sv
// Golden full-adder model: {A,B,Ci} -> {Co,S}.
module adder_golden
  import adder_check_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [1:0]       sum
);

  always_comb begin
    sum = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  end

endmodule

// File: rtl/adder_checker.sv
// Response checker for a single-bit full adder under test.
// Optional coverage tracking enabled by defining ADDER_CHECKER_COVERAGE_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARMED  | ready for the next vector strobe
// SETTLE | counting down before sampling S/Co
// DONE   | run finished, results held until start
module adder_checker
  import adder_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 10,
  parameter int VECTOR_COUNT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             A,
  input  logic             B,
  input  logic             Ci,
  input  logic             S,
  input  logic             Co,
  output logic             ready,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun,
  output logic [VEC_W-1:0] first_fail,
  output logic             first_fail_vld,
  output logic [7:0]       cov_mask
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_IDX    = 8'(VECTOR_COUNT - 1);

  state_e state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       vec_cnt_q, vec_cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ovr_q, ovr_d;
  logic [VEC_W-1:0] ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             cov_ok;
`ifdef ADDER_CHECKER_COVERAGE_EN
  logic [7:0]       cov_q, cov_d;
`endif

  logic [1:0] gold;
  logic       arm, accept, expire, mismatch, last_vec;

  adder_golden u_golden (
    .vec (vec_q),
    .sum (gold)
  );

  assign arm      = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign accept   = (state_q == ARMED) && vec_valid;
  assign expire   = (state_q == SETTLE) && (cnt_q == 8'd1);
  assign mismatch = expire && ({Co, S} != gold);
  assign last_vec = (vec_cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARMED;
      ARMED:   if (vec_valid) state_d = SETTLE;
      SETTLE:  if (expire) state_d = last_vec ? DONE : ARMED;
      DONE:    if (start) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    vec_cnt_d = vec_cnt_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;
`ifdef ADDER_CHECKER_COVERAGE_EN
    cov_d     = cov_q;
`endif
    if (arm) begin
      vec_cnt_d = '0;
      err_d     = '0;
      ovr_d     = 1'b0;
      ff_d      = '0;
      ffv_d     = 1'b0;
`ifdef ADDER_CHECKER_COVERAGE_EN
      cov_d     = '0;
`endif
    end
    if (accept) begin
      vec_d = {A, B, Ci};
      cnt_d = SETTLE_LOAD;
    end
    if (state_q == SETTLE) begin
      // A strobe during settling is dropped; only the overrun flag records it.
      if (vec_valid) ovr_d = 1'b1;
      if (expire) begin
        vec_cnt_d = vec_cnt_q + 8'd1;
`ifdef ADDER_CHECKER_COVERAGE_EN
        cov_d[vec_q] = 1'b1;
`endif
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
`ifdef ADDER_CHECKER_COVERAGE_EN
    cov_ok  = (VECTOR_COUNT < 8) || (cov_d == 8'hFF);
`else
    cov_ok  = 1'b1;
`endif
    ready_d = (state_d == ARMED);
    done_d  = (state_d == DONE);
    pass_d  = done_d && (err_d == '0) && !ovr_d && cov_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      vec_q     <= '0;
      vec_cnt_q <= '0;
      err_q     <= '0;
      ovr_q     <= 1'b0;
      ff_q      <= '0;
      ffv_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef ADDER_CHECKER_COVERAGE_EN
      cov_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      vec_cnt_q <= vec_cnt_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      ff_q      <= ff_d;
      ffv_q     <= ffv_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef ADDER_CHECKER_COVERAGE_EN
      cov_q     <= cov_d;
`endif
    end
  end

  assign ready          = ready_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign overrun        = ovr_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
`ifdef ADDER_CHECKER_COVERAGE_EN
  assign cov_mask       = cov_q;
`else
  assign cov_mask       = '0;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Scoreboard bench for adder_checker: a main instance (settle 10, 8 vectors)
// and a saturation instance (settle 1, 255 vectors).
module tb_adder_checker;

  typedef struct packed {
    logic       done;
    logic       pass;
    logic       ovr;
    logic [7:0] err;
    logic       ffv;
    logic [2:0] ff;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, vec_valid, A, B, Ci, S, Co;
  logic ready, done, pass, overrun, first_fail_vld;
  logic [7:0] err_count, cov_mask;
  logic [2:0] first_fail;

  logic s_rst, s_start, s_vv, s_A, s_B, s_Ci, s_S, s_Co;
  logic s_ready, s_done, s_pass, s_overrun, s_ffv;
  logic [7:0] s_err, s_cov;
  logic [2:0] s_ff;

  adder_checker #(.SETTLE_CYCLES(10), .VECTOR_COUNT(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
    .A(A), .B(B), .Ci(Ci), .S(S), .Co(Co),
    .ready(ready), .done(done), .pass(pass), .err_count(err_count),
    .overrun(overrun), .first_fail(first_fail), .first_fail_vld(first_fail_vld),
    .cov_mask(cov_mask)
  );

  adder_checker #(.SETTLE_CYCLES(1), .VECTOR_COUNT(255)) u_sat (
    .clk(clk), .rst(s_rst), .start(s_start), .vec_valid(s_vv),
    .A(s_A), .B(s_B), .Ci(s_Ci), .S(s_S), .Co(s_Co),
    .ready(s_ready), .done(s_done), .pass(s_pass), .err_count(s_err),
    .overrun(s_overrun), .first_fail(s_ff), .first_fail_vld(s_ffv),
    .cov_mask(s_cov)
  );

  int n_checks = 0;
  int n_fail   = 0;
  rec_t q_main[$];
  rec_t q_sat[$];
  logic [1:0] gold_tab [8];
  logic [7:0] exp_cov;

  // bench-side expectation of the running results for the main instance
  int   e_err;
  logic e_ffv, e_ovr;
  logic [2:0] e_ff;

  task automatic check_rec(input string name, input rec_t exp, input rec_t act);
    n_checks++;
    if (!exp.done) begin
      exp.pass = 1'b0;
      act.pass = 1'b0;
    end
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got done=%b pass=%b ovr=%b err=%0d ffv=%b ff=%b, required done=%b pass=%b ovr=%b err=%0d ffv=%b ff=%b",
               name, act.done, act.pass, act.ovr, act.err, act.ffv, act.ff,
               exp.done, exp.pass, exp.ovr, exp.err, exp.ffv, exp.ff);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every rise of ready or done is one observable result.
  logic mon_en = 1'b0;
  logic m_rdy_p = 1'b0, m_done_p = 1'b0, s_rdy_p = 1'b0, s_done_p = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if ((ready === 1'b1 && !m_rdy_p) || (done === 1'b1 && !m_done_p)) begin
        if (q_main.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL main_unexpected_event: got ready=%b done=%b, required no event", ready, done);
        end else begin
          check_rec("main_event", q_main.pop_front(),
                    rec_t'{done, pass, overrun, err_count, first_fail_vld, first_fail});
        end
      end
      if ((s_ready === 1'b1 && !s_rdy_p) || (s_done === 1'b1 && !s_done_p)) begin
        if (q_sat.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sat_unexpected_event: got ready=%b done=%b, required no event", s_ready, s_done);
        end else begin
          check_rec("sat_event", q_sat.pop_front(),
                    rec_t'{s_done, s_pass, s_overrun, s_err, s_ffv, s_ff});
        end
      end
      m_rdy_p  = (ready === 1'b1);
      m_done_p = (done === 1'b1);
      s_rdy_p  = (s_ready === 1'b1);
      s_done_p = (s_done === 1'b1);
    end
  end

  task automatic do_start(input bit with_vec);
    q_main.push_back(rec_t'{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0});
    e_err = 0;
    e_ffv = 1'b0;
    e_ff  = 3'd0;
    e_ovr = 1'b0;
    start = 1'b1;
    if (with_vec) vec_valid = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    vec_valid = 1'b0;
  endtask

  // One vector on the main instance, 12 cycles long. {Co,S} is 'pre' until
  // just after edge E0+sw, then 'post' (sw=0: post from E0 on).
  task automatic do_vec(input logic [2:0] v, input logic [1:0] pre, input logic [1:0] post,
                        input int sw, input bit ovr_pulse, input bit last);
    logic [1:0] sampled;
    logic       e_pass;
    {A, B, Ci} = v;
    vec_valid  = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    {Co, S}   = (sw == 0) ? post : pre;
    sampled   = (sw < 10) ? post : pre;
    if (sampled != gold_tab[v]) begin
      if (e_err < 255) e_err++;
      if (!e_ffv) begin
        e_ffv = 1'b1;
        e_ff  = v;
      end
    end
    if (ovr_pulse) e_ovr = 1'b1;
    e_pass = last && (e_err == 0) && !e_ovr;
    q_main.push_back(rec_t'{last, e_pass, e_ovr, 8'(e_err), e_ffv, e_ff});
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (ovr_pulse && k == 2) begin
        vec_valid  = 1'b1;
        {A, B, Ci} = ~v;
      end
      if (ovr_pulse && k == 3) vec_valid = 1'b0;
      if (k == sw) {Co, S} = post;
    end
  endtask

  task automatic run_correct();
    do_start(1'b0);
    for (int v = 0; v < 8; v++) begin
      do_vec(3'(v), gold_tab[v], gold_tab[v], 0, 1'b0, v == 7);
    end
    @(negedge clk);
    check_val("correct_pass", {31'd0, pass}, 32'd1);
    check_val("correct_cov_mask", {24'd0, cov_mask}, {24'd0, exp_cov});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] prev;
    gold_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
`ifdef ADDER_CHECKER_COVERAGE_EN
    exp_cov = 8'hFF;
`else
    exp_cov = 8'h00;
`endif
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; {A, B, Ci} = 3'd0; {Co, S} = 2'd0;
    s_rst = 1'b1; s_start = 1'b0; s_vv = 1'b0; {s_A, s_B, s_Ci} = 3'd0; {s_Co, s_S} = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_main_outputs",
              {15'd0, ready, done, pass, err_count, overrun, first_fail, first_fail_vld}, 32'd0);
    check_val("reset_main_cov", {24'd0, cov_mask}, 32'd0);
    check_val("reset_sat_outputs",
              {15'd0, s_ready, s_done, s_pass, s_err, s_overrun, s_ff, s_ffv}, 32'd0);
    rst = 1'b0; s_rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // exhaustive, correct responses
    run_correct();

    // stuck-at-0 carry; start and vec_valid together in DONE
    do_start(1'b1);
    for (int v = 0; v < 8; v++) begin
      prev = {1'b0, gold_tab[v][0]};
      do_vec(3'(v), prev, prev, 0, 1'b0, v == 7);
    end
    @(negedge clk);
    check_val("stuck_err_count", {24'd0, err_count}, 32'd4);
    check_val("stuck_first_fail", {29'd0, first_fail}, 32'd3);
    check_val("stuck_pass", {31'd0, pass}, 32'd0);

    // late response: new value only after the sample edge
    do_start(1'b0);
    {Co, S} = 2'd0;
    prev = 2'd0;
    for (int v = 0; v < 8; v++) begin
      do_vec(3'(v), prev, gold_tab[v], 11, 1'b0, v == 7);
      prev = gold_tab[v];
    end
    @(negedge clk);
    check_val("late_err_count", {24'd0, err_count}, 32'd5);
    check_val("late_first_fail", {29'd0, first_fail}, 32'd1);

    // overrun: extra strobe 3 cycles after the first vector
    do_start(1'b0);
    for (int v = 0; v < 8; v++) begin
      do_vec(3'(v), gold_tab[v], gold_tab[v], 0, v == 0, v == 7);
    end
    @(negedge clk);
    check_val("overrun_flag", {31'd0, overrun}, 32'd1);
    check_val("overrun_err_count", {24'd0, err_count}, 32'd0);
    check_val("overrun_pass", {31'd0, pass}, 32'd0);

    // reset asserted so it is sampled at E0+4 of a mismatching vector
    do_start(1'b0);
    {A, B, Ci} = 3'b111;
    {Co, S}    = 2'd0;
    vec_valid  = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midreset_outputs",
              {15'd0, ready, done, pass, err_count, overrun, first_fail, first_fail_vld}, 32'd0);
    check_val("midreset_cov", {24'd0, cov_mask}, 32'd0);
    vec_valid = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_val("idle_ignores_vec", {30'd0, ready, done}, 32'd0);
    @(posedge clk); #1;
    run_correct();

    // saturation instance: 255 vectors, every response wrong
    q_sat.push_back(rec_t'{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0});
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      logic [2:0] sv;
      sv = 3'(i);
      {s_A, s_B, s_Ci} = sv;
      {s_Co, s_S}      = ~gold_tab[sv];
      s_vv             = 1'b1;
      q_sat.push_back(rec_t'{i == 254, 1'b0, 1'b0, 8'(i + 1), 1'b1, 3'd0});
      @(posedge clk); #1;
      s_vv = 1'b0;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("sat_err_hold", {24'd0, s_err}, 32'd255);
    check_val("sat_done_pass", {30'd0, s_done, s_pass}, 32'd2);
    q_sat.push_back(rec_t'{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0});
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    check_val("sat_restart", {22'd0, s_ready, s_done, s_err}, {22'd0, 1'b1, 1'b0, 8'd0});

    repeat (3) @(posedge clk);
    check_val("main_queue_drained", q_main.size(), 32'd0);
    check_val("sat_queue_drained", q_sat.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
